// File: rtl/dmemory_dbg_if.sv
// Bus bundle for dmemory_dbg: memory access port, debug buttons and watch outputs.
// The memory sits on the slave side; the pipeline/bench drives the master side.
interface dmemory_dbg_if #(
    parameter int WIDTH = 32
) ();
    logic                 mem_write;
    logic                 mem_read;
    logic [WIDTH-1:0]     write_address;
    logic [WIDTH-1:0]     read_address;
    logic [WIDTH-1:0]     write_data;
    logic [WIDTH/8-1:0]   byte_en;
    logic [WIDTH-1:0]     mem_data;
    logic                 rd_valid;
    logic                 addr_err;
    logic                 button_up;
    logic                 button_down;
    logic [3:0]           disp_index;
    logic [WIDTH-1:0]     disp_data;

    modport master (
        output mem_write, mem_read, write_address, read_address, write_data, byte_en,
        output button_up, button_down,
        input  mem_data, rd_valid, addr_err, disp_index, disp_data
    );

    modport slave (
        input  mem_write, mem_read, write_address, read_address, write_data, byte_en,
        input  button_up, button_down,
        output mem_data, rd_valid, addr_err, disp_index, disp_data
    );
endinterface

// File: rtl/dmemory_dbg.sv
// Data memory with byte-enable writes, registered reads and a button-stepped debug watch port.
// Latency: 1 cycle read and watch; button to index 2+DEBOUNCE+1 cycles. No backpressure.
// DMEM_BYPASS_EN: same-cycle read/write of one word returns merged data instead of read-first.
module dmemory_dbg #(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH      = 1024,
    parameter int          NUM_WATCH  = 8,
    parameter int          WATCH_BASE = 0,
    parameter logic [19:0] DEBOUNCE   = 20'd500000
) (
    input  logic           clk,
    input  logic           reset,
    dmemory_dbg_if.slave   bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          NB       = WIDTH / 8;
    localparam logic [19:0] DB_LAST  = DEBOUNCE - 20'd1;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_WATCH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_idx, rd_idx, watch_idx;
    logic             wr_oor, rd_oor, wr_en;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] mem_data_q, mem_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             addr_err_q, addr_err_d;
    logic [WIDTH-1:0] disp_data_q, disp_data_d;
    logic [3:0]       disp_index_q, disp_index_d;

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       lvl_q, lvl_d, acc_q, acc_d, press;
    logic [1:0][19:0] cnt_q, cnt_d;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.write_address[1:0], bus.read_address[1:0]};

    assign wr_idx    = bus.write_address[AW+1:2];
    assign rd_idx    = bus.read_address[AW+1:2];
    assign wr_oor    = |bus.write_address[WIDTH-1:AW+2];
    assign rd_oor    = |bus.read_address[WIDTH-1:AW+2];
    assign wr_en     = bus.mem_write && !wr_oor && !reset;
    assign watch_idx = AW'(WATCH_BASE / 4) + AW'(disp_index_q);

    // Array is deliberately outside the reset domain so reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.byte_en[i]) begin
                    mem[wr_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_idx];
`ifdef DMEM_BYPASS_EN
        if (bus.mem_write && !wr_oor && (wr_idx == rd_idx)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.byte_en[i]) begin
                    rd_word[8*i +: 8] = bus.write_data[8*i +: 8];
                end
            end
        end
`endif
    end

    always_comb begin
        mem_data_d  = mem_data_q;
        rd_valid_d  = 1'b0;
        addr_err_d  = (bus.mem_read && rd_oor) || (bus.mem_write && wr_oor);
        disp_data_d = mem[watch_idx];
        if (bus.mem_read) begin
            rd_valid_d = 1'b1;
            mem_data_d = rd_oor ? '0 : rd_word;
        end
    end

    // Debounce: counter restarts on every synchronised level change; level accepted once stable.
    always_comb begin
        sync1_d = {bus.button_down, bus.button_up};
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
                lvl_d[b] = sync2_q[b];
                cnt_d[b] = '0;
            end else if (cnt_q[b] >= DB_LAST) begin
                acc_d[b] = lvl_q[b];
            end else begin
                cnt_d[b] = cnt_q[b] + 20'd1;
            end
        end
        press = acc_d & ~acc_q;
    end

    always_comb begin
        disp_index_d = disp_index_q;
        if (press[0] && !press[1]) begin
            disp_index_d = (disp_index_q == LAST_IDX) ? 4'd0 : disp_index_q + 4'd1;
        end else if (press[1] && !press[0]) begin
            disp_index_d = (disp_index_q == 4'd0) ? LAST_IDX : disp_index_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_data_q   <= '0;
            rd_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            disp_data_q  <= '0;
            disp_index_q <= 4'd0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            lvl_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
        end else begin
            mem_data_q   <= mem_data_d;
            rd_valid_q   <= rd_valid_d;
            addr_err_q   <= addr_err_d;
            disp_data_q  <= disp_data_d;
            disp_index_q <= disp_index_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            lvl_q        <= lvl_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.mem_data   = mem_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_index = disp_index_q;
endmodule
